inv_add_round_key: RTL

Round-key store and AddRoundKey stage for the AES inverse cipher, placed directly upstream of the inverse-MixColumns stage. It accepts the 44 expanded round-key words once per key. Per round, it XORs the 128-bit state with the selected round key and presents the result, plus the round index, in a registered output with valid/ready handshaking. The downstream stage uses the round index to decide whether inverse MixColumns applies (rounds 1..NR-1).

---
 rtl/aes_pkg.sv | 29 ++
 rtl/round_key_store.sv | 68 ++++++
 rtl/inv_add_round_key.sv | 90 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, types and state slice helpers
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_WORD_W  = 32;
  localparam int AES_NB      = 4;

  // Big-endian orderings: bit 0 is the MSB of byte 0 / word 0.
  typedef logic [0:3]             round_t;
  typedef logic [0:AES_WORD_W-1]  word_t;
  typedef logic [0:AES_STATE_W-1] state_t;

  // Output register occupancy.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Byte idx (0..15) of a state, byte 0 at bits [0:7].
  function automatic logic [0:7] state_byte(input state_t s, input int unsigned idx);
    return s[8*idx +: 8];
  endfunction

  // Column word idx (0..3) of a state, word 0 at bits [0:31].
  function automatic word_t state_word(input state_t s, input int unsigned idx);
    return s[AES_WORD_W*idx +: AES_WORD_W];
  endfunction

endpackage

// File: rtl/round_key_store.sv
// rtl/round_key_store.sv - expanded round-key memory with word-serial loader
module round_key_store
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   key_clear,
  input  logic   key_wr,
  input  word_t  key_word,
  input  round_t rd_round,
  output state_t rd_key,
  output logic   key_ready
);

  localparam int NWORDS = AES_NB * (NR + 1);
  localparam int CNT_W  = $clog2(NWORDS);
  localparam int ROW_W  = CNT_W - 2;
  localparam round_t           LAST_ROUND = round_t'(NR);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(NWORDS - 1);

  logic [CNT_W-1:0] cnt;
  logic [ROW_W-1:0] row;
  logic [1:0]       slot;
  logic             wr_en;

  // Key contents survive reset and clear; only a reload replaces them.
  state_t key_mem [0:NR];

  assign row   = cnt[CNT_W-1:2];
  assign slot  = cnt[1:0];
  // Clear wins over a same-cycle write; writes after the last word are dropped.
  assign wr_en = key_wr && !key_clear && !key_ready;

  // Word counter and load-complete flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      key_ready <= 1'b0;
    end else if (key_clear) begin
      cnt       <= '0;
      key_ready <= 1'b0;
    end else if (wr_en) begin
      if (cnt == LAST_CNT) begin
        key_ready <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Key word write into its round-key row, word 0 at the MSB end.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      key_mem[row][{slot, 5'b00000} +: AES_WORD_W] <= key_word;
    end
  end

  // Combinational read port; out-of-range rounds read as zero.
  always_comb begin
    rd_key = '0;
    if (rd_round <= LAST_ROUND) begin
      rd_key = key_mem[rd_round];
    end
  end

endmodule

// File: rtl/inv_add_round_key.sv
// rtl/inv_add_round_key.sv - inverse-cipher AddRoundKey stage with registered handshake output
module inv_add_round_key
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_key_clear,
  input  logic         i_key_wr,
  input  logic [0:31]  i_key_word,
  output logic         o_key_ready,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [0:127] i_data,
  input  logic [0:3]   i_round,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [0:127] o_data,
  output logic [0:3]   o_round,
  output logic         o_error
);

  localparam round_t LAST_ROUND = round_t'(NR);

  out_state_t out_state;
  state_t     round_key;
  logic       xfer;
  logic       bad_round;
  logic       good_xfer;

  round_key_store #(
    .NR(NR)
  ) u_store (
    .clk      (i_clock),
    .rst_n    (i_reset_n),
    .key_clear(i_key_clear),
    .key_wr   (i_key_wr),
    .key_word (i_key_word),
    .rd_round (i_round),
    .rd_key   (round_key),
    .key_ready(o_key_ready)
  );

  assign o_valid   = (out_state == OUT_FULL);
  assign o_ready   = o_key_ready && (!o_valid || i_ready);
  assign xfer      = i_valid && o_ready;
  assign bad_round = (i_round > LAST_ROUND);
  assign good_xfer = xfer && !bad_round;

  // Output register: fill on a good transfer, drain when taken with nothing new.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_state <= OUT_EMPTY;
      o_data    <= '0;
      o_round   <= '0;
    end else begin
      case (out_state)
        OUT_EMPTY: begin
          if (good_xfer) begin
            o_data    <= i_data ^ round_key;
            o_round   <= i_round;
            out_state <= OUT_FULL;
          end
        end
        OUT_FULL: begin
          if (good_xfer) begin
            o_data  <= i_data ^ round_key;
            o_round <= i_round;
          end else if (i_ready) begin
            out_state <= OUT_EMPTY;
          end
        end
        default: out_state <= OUT_EMPTY;
      endcase
    end
  end

  // Sticky flag for consumed inputs naming a round beyond NR.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_error <= 1'b0;
    end else if (i_key_clear) begin
      o_error <= 1'b0;
    end else if (xfer && bad_round) begin
      o_error <= 1'b1;
    end
  end

endmodule
